// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: receives PS/2 keyboard frames (scan code set 2), decodes
// make/break/extended sequences and drives a held 8-bit key code plus a
// one-cycle strobe on each new key.
// Optional build macro: PS2_PARITY_CHECK_EN -- when defined, frames with bad
// odd parity are dropped and flagged on frame_err; otherwise parity is ignored.
module ps2_key_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 130000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key,
  output logic       key_strobe,
  output logic       frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {DEC_MAKE, DEC_BREAK, DEC_EXT, DEC_EXT_BREAK} dec_state_t;

  logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic            r_fclk;
  logic [FW-1:0]   r_fcnt;
  logic            w_sample;
  rx_state_t       r_rx_state, w_rx_next;
  logic [2:0]      r_bitcnt;
  logic [7:0]      r_shift;
  logic [7:0]      r_byte;
  logic [TW-1:0]   r_tcnt;
  logic            w_timeout;
  logic            w_frame_ok;
  logic            r_stop_good, r_byte_valid;
  dec_state_t      r_dec_state, w_dec_next;
  logic            w_is_make, w_is_break, w_ext;
  logic [7:0]      w_code;
  logic [7:0]      r_key;
  logic            r_key_strobe, r_frame_err;
`ifdef PS2_PARITY_CHECK_EN
  logic            r_parity;
`endif

  // Scan code set 2 to key code; 8'h00 means unmapped.
  function automatic logic [7:0] f_translate(input logic ext, input logic [7:0] code);
    logic [7:0] res;
    res = 8'h00;
    if (ext) begin
      case (code)
        8'h75: res = 8'h80;
        8'h72: res = 8'h81;
        8'h6B: res = 8'h82;
        8'h74: res = 8'h83;
        default: res = 8'h00;
      endcase
    end else begin
      case (code)
        8'h16: res = 8'h31;
        8'h1E: res = 8'h32;
        8'h26: res = 8'h33;
        8'h25: res = 8'h34;
        8'h2E: res = 8'h35;
        8'h36: res = 8'h36;
        8'h3D: res = 8'h37;
        8'h3E: res = 8'h38;
        8'h46: res = 8'h39;
        8'h45: res = 8'h30;
        8'h76: res = 8'h1B;
        8'h5A: res = 8'h0D;
        8'h29: res = 8'h20;
        8'h1D: res = 8'h77;
        8'h1C: res = 8'h61;
        8'h1B: res = 8'h73;
        8'h23: res = 8'h64;
        default: res = 8'h00;
      endcase
    end
    return res;
  endfunction

  // Two-flop synchronizers; both lines idle high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Glitch filter: filtered clock follows only after FILTER_LEN equal samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fclk <= 1'b1;
      r_fcnt <= '0;
    end else if (r_clk_s2 != r_fclk) begin
      if (r_fcnt == FILT_LAST) begin
        r_fclk <= r_clk_s2;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + FW'(1);
      end
    end else begin
      r_fcnt <= '0;
    end
  end

  // Sample point: the cycle in which the filtered clock falls.
  assign w_sample  = r_fclk & ~r_clk_s2 & (r_fcnt == FILT_LAST);
  assign w_timeout = (r_rx_state != RX_IDLE) && (r_tcnt == TO_LAST);

`ifdef PS2_PARITY_CHECK_EN
  assign w_frame_ok = r_dat_s2 & (^{r_shift, r_parity});
`else
  assign w_frame_ok = r_dat_s2;
`endif

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (rst) r_rx_state <= RX_IDLE;
    else     r_rx_state <= w_rx_next;
  end

  // Receiver next state: one step per sample point; a sample beats a timeout.
  always_comb begin
    w_rx_next = r_rx_state;
    if (w_sample) begin
      case (r_rx_state)
        RX_IDLE:   if (!r_dat_s2) w_rx_next = RX_DATA;
        RX_DATA:   if (r_bitcnt == 3'd7) w_rx_next = RX_PARITY;
        RX_PARITY: w_rx_next = RX_STOP;
        RX_STOP:   w_rx_next = RX_IDLE;
        default:   w_rx_next = RX_IDLE;
      endcase
    end else if (w_timeout) begin
      w_rx_next = RX_IDLE;
    end
  end

  // Receiver datapath: shift register, timeout counter, byte/error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_byte       <= '0;
      r_tcnt       <= '0;
      r_stop_good  <= 1'b0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      r_stop_good  <= 1'b0;
      r_frame_err  <= 1'b0;
      r_byte_valid <= r_stop_good;
      if (r_rx_state == RX_IDLE || w_sample) r_tcnt <= '0;
      else                                   r_tcnt <= r_tcnt + TW'(1);
      if (w_sample) begin
        case (r_rx_state)
          RX_IDLE: r_bitcnt <= '0;
          RX_DATA: begin
            r_shift  <= {r_dat_s2, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
          end
          RX_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            r_parity <= r_dat_s2;
`endif
          end
          RX_STOP: begin
            if (w_frame_ok) begin
              r_stop_good <= 1'b1;
              r_byte      <= r_shift;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          default: r_bitcnt <= '0;
        endcase
      end else if (w_timeout) begin
        r_frame_err <= 1'b1;
      end
    end
  end

  // Decoder state register.
  always_ff @(posedge clk) begin
    if (rst) r_dec_state <= DEC_MAKE;
    else     r_dec_state <= w_dec_next;
  end

  // Decoder next state: classifies each valid byte as prefix, make or break.
  always_comb begin
    w_dec_next = r_dec_state;
    w_is_make  = 1'b0;
    w_is_break = 1'b0;
    w_ext      = 1'b0;
    if (r_byte_valid) begin
      case (r_dec_state)
        DEC_MAKE: begin
          if (r_byte == 8'hF0)      w_dec_next = DEC_BREAK;
          else if (r_byte == 8'hE0) w_dec_next = DEC_EXT;
          else                      w_is_make  = 1'b1;
        end
        DEC_BREAK: begin
          w_is_break = 1'b1;
          w_dec_next = DEC_MAKE;
        end
        DEC_EXT: begin
          if (r_byte == 8'hF0) begin
            w_dec_next = DEC_EXT_BREAK;
          end else begin
            w_is_make  = 1'b1;
            w_ext      = 1'b1;
            w_dec_next = DEC_MAKE;
          end
        end
        default: begin
          w_is_break = 1'b1;
          w_ext      = 1'b1;
          w_dec_next = DEC_MAKE;
        end
      endcase
    end
  end

  assign w_code = f_translate(w_ext, r_byte);

  // Key register: new mapped make latches and strobes; matching break clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key        <= 8'h00;
      r_key_strobe <= 1'b0;
    end else begin
      r_key_strobe <= 1'b0;
      if (w_is_make && (w_code != 8'h00) && (w_code != r_key)) begin
        r_key        <= w_code;
        r_key_strobe <= 1'b1;
      end else if (w_is_break && (w_code != 8'h00) && (w_code == r_key)) begin
        r_key <= 8'h00;
      end
    end
  end

  assign key        = r_key;
  assign key_strobe = r_key_strobe;
  assign frame_err  = r_frame_err;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed scenarios followed by random scan-code traffic
// checked against a table-driven model of the keyboard decoding rules.
module tb_ps2_key_decoder;
  localparam int FL   = 8;
  localparam int TO   = 1000;
  localparam int HALF = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key;
  logic       key_strobe;
  logic       frame_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_strobe = 0;
  int n_err = 0;
  int last_strobe_cyc = -1;
  int last_err_cyc = -1;
  int fall_cyc = 0;

  logic [7:0] tbl_norm [logic [7:0]];
  logic [7:0] tbl_ext  [logic [7:0]];
  logic [7:0] pool [$];

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key(key), .key_strobe(key_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts strobes and errors, remembering the cycle of each.
  always begin
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    if (key_strobe === 1'b1) begin n_strobe = n_strobe + 1; last_strobe_cyc = cyc; end
    if (frame_err === 1'b1) begin n_err = n_err + 1; last_err_cyc = cyc; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive the first nbits bits of a frame: start, 8 data LSB first, parity, stop.
  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop, input int nbits);
    logic [10:0] bits;
    logic        par;
    logic        stp;
    par  = (~(^b)) ^ flip_par;
    stp  = ~bad_stop;
    bits = {stp, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      wait_cyc(HALF);
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      wait_cyc(HALF);
      ps2_clk  = 1'b1;
    end
    wait_cyc(HALF);
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
    wait_cyc(20);
  endtask

  function automatic logic [7:0] xlate(input bit ext, input logic [7:0] c);
    if (ext) return tbl_ext.exists(c) ? tbl_ext[c] : 8'h00;
    return tbl_norm.exists(c) ? tbl_norm[c] : 8'h00;
  endfunction

  initial begin
    int s0, e0;
    logic [7:0] m_key, b, c;
    bit m_ext, m_brk, exp_str, bad;
    logic [7:0] digits [10];
    digits = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
    for (int i = 0; i < 10; i++) begin
      tbl_norm[digits[i]] = (i == 9) ? 8'h30 : 8'(8'h31 + i);
      pool.push_back(digits[i]);
    end
    tbl_norm[8'h76] = 8'h1B; tbl_norm[8'h5A] = 8'h0D; tbl_norm[8'h29] = 8'h20;
    tbl_norm[8'h1D] = 8'h77; tbl_norm[8'h1C] = 8'h61; tbl_norm[8'h1B] = 8'h73;
    tbl_norm[8'h23] = 8'h64;
    tbl_ext[8'h75] = 8'h80; tbl_ext[8'h72] = 8'h81;
    tbl_ext[8'h6B] = 8'h82; tbl_ext[8'h74] = 8'h83;
    pool.push_back(8'h76); pool.push_back(8'h1D); pool.push_back(8'h1C);
    pool.push_back(8'h23); pool.push_back(8'h75); pool.push_back(8'h72);
    pool.push_back(8'h6B); pool.push_back(8'h74); pool.push_back(8'h11);

    // Reset state
    wait_cyc(5);
    chk("reset_key", 32'(key), 32'h00);
    chk("reset_strobe", 32'(key_strobe), 32'h0);
    chk("reset_err", 32'(frame_err), 32'h0);
    rst = 1'b0;
    wait_cyc(20);

    // Digit 1 make, strobe latency, then break
    s0 = n_strobe;
    send(8'h16);
    chk("make16_key", 32'(key), 32'h31);
    chk("make16_strobes", 32'(n_strobe - s0), 32'd1);
    chk("make16_latency", 32'(last_strobe_cyc - fall_cyc), 32'(FL + 4));
    send(8'hF0); send(8'h16);
    chk("brk16_key", 32'(key), 32'h00);
    chk("brk16_strobes", 32'(n_strobe - s0), 32'd1);

    // Typematic repeat of ESC
    s0 = n_strobe;
    send(8'h76); send(8'h76); send(8'h76);
    chk("esc_key", 32'(key), 32'h1B);
    chk("esc_strobes", 32'(n_strobe - s0), 32'd1);
    send(8'hF0); send(8'h76);
    chk("esc_brk_key", 32'(key), 32'h00);

    // Extended up arrow, its break, then a bare 75 is unmapped
    s0 = n_strobe;
    send(8'hE0); send(8'h75);
    chk("up_key", 32'(key), 32'h80);
    chk("up_strobes", 32'(n_strobe - s0), 32'd1);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("up_brk_key", 32'(key), 32'h00);
    send(8'h16);
    s0 = n_strobe;
    send(8'h75);
    chk("bare75_key", 32'(key), 32'h31);
    chk("bare75_strobes", 32'(n_strobe - s0), 32'd0);
    send(8'hF0); send(8'h16);
    chk("bare75_clear", 32'(key), 32'h00);

    // Flipped parity on 'a'
    e0 = n_err;
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    wait_cyc(20);
`ifdef PS2_PARITY_CHECK_EN
    chk("par_err", 32'(n_err - e0), 32'd1);
    chk("par_key", 32'(key), 32'h00);
`else
    chk("par_err", 32'(n_err - e0), 32'd0);
    chk("par_key", 32'(key), 32'h61);
    send(8'hF0); send(8'h1C);
    chk("par_clear", 32'(key), 32'h00);
`endif

    // Partial frame then silence: timeout
    e0 = n_err;
    send_frame(8'h1D, 1'b0, 1'b0, 5);
    wait_cyc(TO + 40);
    chk("to_err", 32'(n_err - e0), 32'd1);
    chk("to_err_cycle", 32'(last_err_cyc - fall_cyc), 32'(TO + FL + 2));
    send(8'h1D);
    chk("to_next_key", 32'(key), 32'h77);
    send(8'hF0); send(8'h1D);

    // Reset in the middle of a second frame
    send(8'h1E);
    chk("hold1e_key", 32'(key), 32'h32);
    s0 = n_strobe; e0 = n_err;
    send_frame(8'h26, 1'b0, 1'b0, 5);
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(TO + 40);
    chk("rst_key", 32'(key), 32'h00);
    chk("rst_strobes", 32'(n_strobe - s0), 32'd0);
    chk("rst_errs", 32'(n_err - e0), 32'd0);
    send(8'h26);
    chk("rst_next_key", 32'(key), 32'h33);

    // Random traffic against the rule model
    m_key = 8'h33; m_ext = 1'b0; m_brk = 1'b0;
    for (int n = 0; n < 30; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 3)       b = 8'hF0;
      else if (r == 3) b = 8'hE0;
      else             b = pool[$urandom_range(0, pool.size() - 1)];
      bad = ($urandom_range(0, 9) == 0);
      exp_str = 1'b0;
      if (!bad) begin
        if (m_brk) begin
          c = xlate(m_ext, b);
          if (c != 8'h00 && c == m_key) m_key = 8'h00;
          m_brk = 1'b0; m_ext = 1'b0;
        end else if (b == 8'hF0) begin
          m_brk = 1'b1;
        end else if (b == 8'hE0 && !m_ext) begin
          m_ext = 1'b1;
        end else begin
          c = xlate(m_ext, b);
          m_ext = 1'b0;
          if (c != 8'h00 && c != m_key) begin m_key = c; exp_str = 1'b1; end
        end
      end
      s0 = n_strobe; e0 = n_err;
      send_frame(b, 1'b0, bad, 11);
      wait_cyc(20);
      chk($sformatf("rnd%0d_byte%02h_key", n, b), 32'(key), 32'(m_key));
      chk($sformatf("rnd%0d_strobes", n), 32'(n_strobe - s0), 32'(exp_str));
      chk($sformatf("rnd%0d_errs", n), 32'(n_err - e0), 32'(bad));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Upstream feeder for the menu overlay and game control: receives PS/2 keyboard frames (scan code set 2) and translates make/break sequences into the 8-bit ASCII-style key code on the shared key bus. The key is held while the key is physically pressed and cleared on release. A one-cycle strobe marks each new key.

Parameters:
FILTER_LEN, 8, consecutive equal synchronized samples required before filtered ps2_clk changes state.
TIMEOUT, 130000, clk cycles without a ps2_clk falling edge before a partial frame is aborted (2 ms at 65 MHz).

Ports:
clk  input  1  system clock (pixel clock domain).
rst  input  1  reset.
ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous.
ps2_data  input  1  raw PS/2 data, asynchronous.
key  output  8  translated key code, held while pressed; 8'h00 when no key is held.
key_strobe  output  1  one-cycle pulse when key takes a new non-zero value.
frame_err  output  1  one-cycle pulse on a bad or aborted frame.
Interface rule: one clock; rst is synchronous and active-high.

Behaviour:
- Reset: key=8'h00, key_strobe=0, frame_err=0; receiver and decoder FSMs return to IDLE/MAKE; filter and timeout counters are cleared. Reset mid-frame discards the partial frame.
- Input path: 2-FF synchronizer on both ps2 lines. Filtered clk toggles only after FILTER_LEN identical samples. A sample point is a 1->0 transition of the filtered clk.
- Receiver FSM, one transition per sample point:
  - IDLE: data=0 -> DATA. Data=1 -> stay in IDLE (glitch, no error).
  - DATA: shift 8 bits in LSB first, then -> PARITY.
  - PARITY: capture bit, then -> STOP.
  - STOP: requires stop=1 and odd parity over data+parity. If good, byte_valid pulses 1 cycle later. If bad, frame_err pulses and the byte is dropped. Always -> IDLE.
- Timeout: the counter runs in any non-IDLE state and resets on each sample point. Reaching TIMEOUT forces IDLE and pulses frame_err. If a timeout and a sample point occur in the same cycle, the sample point wins.
- Decoder FSM, advanced only on byte_valid:
  - MAKE: F0 -> BREAK; E0 -> EXT; any other byte is a make code.
  - BREAK: byte is a break code -> MAKE.
  - EXT: F0 -> EXT_BREAK; any other byte is an extended make -> MAKE.
  - EXT_BREAK: byte is an extended break -> MAKE.
- Translation table:
  - Digits: 16,1E,26,25,2E,36,3D,3E,46,45 -> 31..39,30.
  - Control and letters: 76->1B (ESC), 5A->0D, 29->20, 1D->77 'w', 1C->61 'a', 1B->73 's', 23->64 'd'.
  - Extended: E0 75->80 (up), E0 72->81 (down), E0 6B->82 (left), E0 74->83 (right).
  - Everything else is unmapped.
- Make of a mapped code that differs from key: key <= code and key_strobe=1, both in the same cycle.
- Make equal to the current key (typematic repeat): no change, no strobe.
- Unmapped make: key unchanged, no strobe.
- Break whose translated code equals key: key <= 00, no strobe. Break of any other code: ignored.
- Latency: key/key_strobe update 2 clk cycles after the sample point of the stop bit.
- An E0 or F0 prefix followed by a frame error: the decoder remains in its prefix state until the next valid byte.

Optional Feature:
PS2_PARITY_CHECK_EN.
- Defined: parity is checked as described above; a parity failure drops the byte and pulses frame_err.
- Undefined: the parity bit is sampled but ignored; only a bad stop bit or a timeout raises frame_err.

Test Plan:
- Frame 16 with parity 0, stop 1 -> key=31 and one key_strobe pulse 2 clk after the stop sample; then frames F0,16 -> key=00, no strobe.
- Frames 76 sent three times (typematic) -> key=1B with exactly one strobe; frames F0,76 -> key=00.
- Frames E0,75 -> key=80 with a strobe; then E0,F0,75 -> key=00; a bare 75 -> key unchanged (unmapped).
- Frame 1C with the parity bit flipped -> frame_err pulse and key stays 00 (with PS2_PARITY_CHECK_EN); without the macro -> key=61.
- Start bit plus 4 data bits, then silence for TIMEOUT cycles -> frame_err pulse at cycle TIMEOUT; a following good frame 1D -> key=77.
- Hold 1E (key=32), assert rst mid-frame of a second byte -> key=00, no strobe or frame_err, and the next full frame 26 decodes to 33.
